write_serial: RTL and testbench
===============================

Name: write_serial

Overview:
- UART transmitter: the send-side counterpart of the serial receiver.
- Accepts bytes through a valid/ready handshake into an internal FIFO and serialises them on Tx as 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit).
- Sits between the AES datapath and the board's serial TX pin, so a full 16-byte cipher block can be queued in one burst and sent back-to-back.

Parameters:
- BoardFreq, 100000000, input clock frequency in Hz (Nexys3).
- BaudRate, 9600, serial bit rate.
- BaudDiv, BoardFreq/BaudRate (integer division, 10416 at defaults), clocks per bit.
- DivBits, 14, width of the baud counter; must satisfy 2^DivBits > BaudDiv.
- FifoDepth, 16, FIFO entries; must be a power of 2.
- PtrBits, 4, log2(FifoDepth).

Ports:
- Clk  input  1  system clock.
- Rst  input  1  asynchronous, active-low reset.
- inputByte  input  8  byte to transmit.
- inputValid  input  1  inputByte is valid this cycle.
- inputReady  output  1  FIFO can accept a byte (not full).
- Tx  output  1  serial line; idles high.
- busy  output  1  a frame is in progress or the FIFO is non-empty.
- txDone  output  1  one-cycle pulse at the end of each stop bit.
- fifoCount  output  PtrBits+1  bytes currently queued.

Behaviour:
- Reset (Rst=0, asynchronous):
  - Tx=1, txDone=0, busy=0, fifoCount=0, inputReady=1.
  - FSM goes to IDLE; baud counter and bit index are cleared; FIFO pointers are cleared and queued data is discarded.
  - Asserting reset mid-frame forces Tx high immediately; the frame is truncated with no completion.
- All outputs are registered except inputReady = (fifoCount != FifoDepth).
- FIFO:
  - Push occurs on a clock edge when inputValid && inputReady.
  - Pop is performed by the FSM only.
  - Push and pop in the same cycle: fifoCount is unchanged.
  - Push while full is ignored; no overwrite and no error flag.
  - Pointers wrap modulo FifoDepth.
- Baud counter:
  - Counts 0..BaudDiv-1 while the FSM is not IDLE.
  - bitTick is asserted on count==BaudDiv-1; the counter then returns to 0.
  - The counter is held at 0 in IDLE, so the first (start) bit lasts exactly BaudDiv clocks.
- FSM states IDLE, START, DATA, STOP:
  - IDLE: Tx=1. If the FIFO is non-empty, pop the head into shift register txShift at the next edge and go to START.
  - START: Tx=0 for BaudDiv clocks. On bitTick go to DATA with bitIdx=0.
  - DATA: Tx=txShift[bitIdx]. On bitTick, if bitIdx==7 go to STOP, else increment bitIdx.
  - STOP: Tx=1 for BaudDiv clocks. On bitTick pulse txDone for one cycle. If the FIFO is non-empty, pop and go directly to START (no idle gap between frames); otherwise go to IDLE.
- Latency: a byte pushed at edge k into an empty FIFO while IDLE is popped at edge k+1, and Tx falls at edge k+1.
- Frame length: exactly 10*BaudDiv clocks, from the Tx falling edge to the end of the stop bit.
- busy = (state != IDLE) || (fifoCount != 0).
  - busy rises the cycle after the first push.
  - busy falls the cycle after the last STOP bitTick, provided the FIFO is empty.
- A push during STOP's final cycle is visible to the pop decision only if fifoCount was already non-zero before that edge. Otherwise the FSM goes to IDLE, then starts one cycle later.

Test Plan:
- Single byte. Params BoardFreq=1000, BaudRate=100 (BaudDiv=10); push 0x55 at cycle 0.
  - Tx: 0 for cycles 1-10, then bits 1,0,1,0,1,0,1,0 at 10 cycles each, then 1 for cycles 91-100.
  - txDone pulses once at cycle 100; busy is low from cycle 101.
- Back-to-back. Push 0xA5, 0x3C, 0xFF on consecutive cycles.
  - Three frames with no idle gap (stop bit of frame n is immediately followed by start bit of frame n+1).
  - Receiver model decodes A5, 3C, FF; exactly 3 txDone pulses.
- Full FIFO. Push 17 bytes 0x00..0x10 continuously while transmission is stalled mid-frame.
  - inputReady is low once fifoCount reaches 16; byte 0x10 is dropped.
  - Bytes 0x00..0x0F are transmitted in order.
- Simultaneous push/pop. Time a push to the cycle the FSM pops (end of STOP) with fifoCount=2.
  - fifoCount stays 2; the data order is preserved.
- Reset mid-frame. Assert Rst=0 asynchronously during DATA bit 3 of 0x0F.
  - Tx=1 within the same cycle; fifoCount=0, busy=0, no txDone.
  - After release, pushing 0x81 yields a clean frame.
- Defaults. BoardFreq=100000000, BaudRate=9600.
  - Frame spans exactly 104160 clocks; each bit lasts 10416 clocks.

Source files
------------

// File: rtl/write_serial.sv
// write_serial: UART 8N1 transmitter with a byte FIFO in front.
// Bytes enter via valid/ready and leave on Tx LSB first.
module write_serial #(
    parameter int BoardFreq = 100000000,
    parameter int BaudRate  = 9600,
    parameter int BaudDiv   = BoardFreq / BaudRate,
    parameter int DivBits   = 14,
    parameter int FifoDepth = 16,
    parameter int PtrBits   = 4
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic [7:0]         inputByte,
    input  logic               inputValid,
    output logic               inputReady,
    output logic               Tx,
    output logic               busy,
    output logic               txDone,
    output logic [PtrBits:0]   fifoCount
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    localparam logic [DivBits-1:0] CntMax  = DivBits'(BaudDiv - 1);
    localparam logic [PtrBits:0]   CntFull = (PtrBits + 1)'(FifoDepth);

    state_e               state_q, state_d;
    logic [DivBits-1:0]   cnt_q, cnt_d;
    logic [2:0]           bit_q, bit_d;
    logic [7:0]           shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;
    logic [PtrBits:0]     count_q, count_d;
    logic [PtrBits-1:0]   wr_q, wr_d;
    logic [PtrBits-1:0]   rd_q, rd_d;
    logic [7:0]           mem_q [FifoDepth];

    logic                 push;
    logic                 pop;
    logic                 bit_tick;
    logic                 fifo_has;

    assign inputReady = (count_q != CntFull);
    assign push       = inputValid && inputReady;
    assign fifo_has   = (count_q != '0);
    assign bit_tick   = (state_q != IDLE) && (cnt_q == CntMax);

    assign Tx        = tx_q;
    assign txDone    = done_q;
    assign busy      = busy_q;
    assign fifoCount = count_q;

    // FIFO pointer and occupancy update; push+pop leaves the count alone
    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (push) begin
            wr_d = wr_q + PtrBits'(1);
        end
        if (pop) begin
            rd_d = rd_q + PtrBits'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + (PtrBits + 1)'(1);
            2'b01:   count_d = count_q - (PtrBits + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Frame sequencer: next state, bit index, shift load and pop request
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fifo_has) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_q];
                    state_d = START;
                end
            end
            START: begin
                if (bit_tick) begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (bit_tick) begin
                    if (fifo_has) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_q];
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Baud counter, held at zero while idle so the start bit is full length
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE || bit_tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + DivBits'(1);
        end
    end

    // Registered outputs computed from the next state so they line up with it
    always_comb begin
        tx_d   = 1'b1;
        done_d = (state_d == STOP) && (cnt_d == CntMax);
        busy_d = (state_d != IDLE) || (count_d != '0);
        unique case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[bit_d];
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

    // State and control registers with asynchronous clear
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            count_q <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            count_q <= count_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
        end
    end

    // FIFO storage; contents need no reset since pointers gate every read
    always_ff @(posedge Clk) begin
        if (push) begin
            mem_q[wr_q] <= inputByte;
        end
    end

endmodule

// File: tb/tb_write_serial.sv
// tb_write_serial: directed bench for the UART transmitter.
// Small-divider instance for framing, default instance for bit timing.
module tb_write_serial;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] in_byte;
    logic       in_valid;
    logic       ready;
    logic       tx;
    logic       busy_o;
    logic       done_o;
    logic [4:0] cnt;

    logic [7:0] def_byte;
    logic       def_valid;
    logic       def_ready;
    logic       def_tx;
    logic       def_busy;
    logic       def_done;
    logic [4:0] def_cnt;

    write_serial #(.BoardFreq(1000), .BaudRate(100)) dut (
        .Clk(clk), .Rst(rst_n),
        .inputByte(in_byte), .inputValid(in_valid), .inputReady(ready),
        .Tx(tx), .busy(busy_o), .txDone(done_o), .fifoCount(cnt)
    );

    write_serial u_def (
        .Clk(clk), .Rst(rst_n),
        .inputByte(def_byte), .inputValid(def_valid), .inputReady(def_ready),
        .Tx(def_tx), .busy(def_busy), .txDone(def_done), .fifoCount(def_cnt)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int base = 0;

    logic       tx_log   [0:2047];
    logic       done_log [0:2047];
    logic       busy_log [0:2047];
    logic [4:0] cnt_log  [0:2047];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cyc - base >= 0 && cyc - base < 2048) begin
            tx_log[cyc - base]   <= tx;
            done_log[cyc - base] <= done_o;
            busy_log[cyc - base] <= busy_o;
            cnt_log[cyc - base]  <= cnt;
        end
    end

    function automatic logic exp_tx(logic [7:0] b, int s, int c);
        int k;
        if (c < s) return 1'b1;
        k = (c - s) / 10;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        return 1'b1;
    endfunction

    function automatic logic [7:0] decode(int s);
        logic [7:0] r;
        for (int b = 0; b < 8; b++) r[b] = tx_log[s + 10 * (b + 1) + 5];
        return r;
    endfunction

    function automatic int done_count(int a, int b);
        int n = 0;
        for (int i = a; i <= b; i++) if (done_log[i] === 1'b1) n++;
        return n;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        def_valid = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic start_log();
        base = cyc;
    endtask

    task automatic wait_log(int c);
        int n = 0;
        while ((cyc - base) <= c && n < 5000) begin
            step();
            n++;
        end
        checks++;
        if ((cyc - base) <= c) begin
            errors++;
            $display("FAIL wait_log: got %0d need %0d", cyc - base, c + 1);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if ({tx, done_o, busy_o, cnt, ready} !== {1'b1, 1'b0, 1'b0, 5'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_small: got %b exp 1_0_0_00000_1",
                     {tx, done_o, busy_o, cnt, ready});
        end
        checks++;
        if ({def_tx, def_done, def_busy, def_cnt, def_ready} !==
            {1'b1, 1'b0, 1'b0, 5'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_default: got %b exp 1_0_0_00000_1",
                     {def_tx, def_done, def_busy, def_cnt, def_ready});
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        int bt = 0, bd = 0, bb = 0, bc = 0;
        do_reset();
        in_byte = 8'h55;
        in_valid = 1'b1;
        step();
        start_log();
        in_valid = 1'b0;
        wait_log(101);
        for (int c = 0; c <= 101; c++) begin
            if (tx_log[c] !== exp_tx(8'h55, 1, c)) bt++;
            if (done_log[c] !== (c == 100)) bd++;
            if (busy_log[c] !== (c <= 100)) bb++;
            if (cnt_log[c] !== ((c == 0) ? 5'd1 : 5'd0)) bc++;
        end
        checks++;
        if (bt != 0) begin errors++; $display("FAIL single_tx: bad cycles %0d exp 0", bt); end
        checks++;
        if (bd != 0) begin errors++; $display("FAIL single_done: bad cycles %0d exp 0", bd); end
        checks++;
        if (bb != 0) begin errors++; $display("FAIL single_busy: bad cycles %0d exp 0", bb); end
        checks++;
        if (bc != 0) begin errors++; $display("FAIL single_count: bad cycles %0d exp 0", bc); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b [3];
        int bt = 0;
        int nd;
        exp_b[0] = 8'hA5;
        exp_b[1] = 8'h3C;
        exp_b[2] = 8'hFF;
        do_reset();
        in_valid = 1'b1;
        in_byte = 8'hA5;
        step();
        start_log();
        in_byte = 8'h3C;
        step();
        in_byte = 8'hFF;
        step();
        in_valid = 1'b0;
        wait_log(305);
        for (int f = 0; f < 3; f++) begin
            checks++;
            if (decode(1 + 100 * f) !== exp_b[f]) begin
                errors++;
                $display("FAIL b2b_byte%0d: got %h exp %h", f, decode(1 + 100 * f), exp_b[f]);
            end
        end
        for (int c = 0; c <= 305; c++) begin
            int f;
            f = (c < 1) ? 0 : ((c - 1) / 100 > 2 ? 2 : (c - 1) / 100);
            if (tx_log[c] !== exp_tx(exp_b[f], 1 + 100 * f, c)) bt++;
        end
        checks++;
        if (bt != 0) begin errors++; $display("FAIL b2b_gapless: bad cycles %0d exp 0", bt); end
        nd = done_count(0, 305);
        checks++;
        if (nd != 3) begin errors++; $display("FAIL b2b_done: got %0d exp 3", nd); end
        checks++;
        if (busy_log[301] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_busy_end: got %b exp 0", busy_log[301]);
        end
    endtask

    task automatic test_full();
        int bad = 0, hi = 0, nd;
        do_reset();
        in_byte = 8'hEE;
        in_valid = 1'b1;
        step();
        start_log();
        in_valid = 1'b0;
        repeat (19) step();
        for (int i = 0; i <= 16; i++) begin
            in_byte = 8'(i);
            in_valid = 1'b1;
            if (i == 15) begin
                checks++;
                if (ready !== 1'b1) begin errors++; $display("FAIL full_ready15: got %b exp 1", ready); end
            end
            if (i == 16) begin
                checks++;
                if (ready !== 1'b0) begin errors++; $display("FAIL full_ready16: got %b exp 0", ready); end
                checks++;
                if (cnt !== 5'd16) begin errors++; $display("FAIL full_count: got %0d exp 16", cnt); end
            end
            step();
        end
        in_valid = 1'b0;
        wait_log(1705);
        checks++;
        if (decode(1) !== 8'hEE) begin errors++; $display("FAIL full_filler: got %h exp ee", decode(1)); end
        for (int k = 0; k < 16; k++) if (decode(101 + 100 * k) !== 8'(k)) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL full_order: bad frames %0d exp 0", bad); end
        for (int c = 1701; c <= 1705; c++) if (tx_log[c] !== 1'b1) hi++;
        checks++;
        if (hi != 0) begin errors++; $display("FAIL full_dropped: low cycles %0d exp 0", hi); end
        nd = done_count(0, 1705);
        checks++;
        if (nd != 17) begin errors++; $display("FAIL full_done: got %0d exp 17", nd); end
    endtask

    task automatic test_push_pop();
        logic [7:0] exp_b [4];
        int bad = 0, nd;
        exp_b[0] = 8'h12;
        exp_b[1] = 8'h34;
        exp_b[2] = 8'h56;
        exp_b[3] = 8'h78;
        do_reset();
        in_valid = 1'b1;
        in_byte = 8'h12;
        step();
        start_log();
        in_byte = 8'h34;
        step();
        in_byte = 8'h56;
        step();
        in_valid = 1'b0;
        repeat (98) step();
        in_byte = 8'h78;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_log(405);
        checks++;
        if (cnt_log[100] !== 5'd2) begin errors++; $display("FAIL pp_count_before: got %0d exp 2", cnt_log[100]); end
        checks++;
        if (cnt_log[101] !== 5'd2) begin errors++; $display("FAIL pp_count_after: got %0d exp 2", cnt_log[101]); end
        for (int f = 0; f < 4; f++) if (decode(1 + 100 * f) !== exp_b[f]) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL pp_order: bad frames %0d exp 0", bad); end
        nd = done_count(0, 405);
        checks++;
        if (nd != 4) begin errors++; $display("FAIL pp_done: got %0d exp 4", nd); end
    endtask

    task automatic test_reset_mid();
        int bt = 0, nd;
        int seen_done = 0;
        do_reset();
        in_valid = 1'b1;
        in_byte = 8'h0F;
        step();
        start_log();
        in_byte = 8'h99;
        step();
        in_valid = 1'b0;
        repeat (44) step();
        checks++;
        if ({cnt, busy_o} !== {5'd1, 1'b1}) begin
            errors++;
            $display("FAIL rm_pre: got cnt=%0d busy=%b exp 1 1", cnt, busy_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({tx, cnt, busy_o, done_o, ready} !== {1'b1, 5'd0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL rm_async: got %b exp 1_00000_0_0_1", {tx, cnt, busy_o, done_o, ready});
        end
        repeat (3) step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (tx !== 1'b1 || busy_o !== 1'b0) bt++;
            if (done_o !== 1'b0) seen_done++;
        end
        checks++;
        if (bt != 0) begin errors++; $display("FAIL rm_idle: bad cycles %0d exp 0", bt); end
        checks++;
        if (seen_done != 0) begin errors++; $display("FAIL rm_no_done: got %0d exp 0", seen_done); end
        bt = 0;
        in_byte = 8'h81;
        in_valid = 1'b1;
        step();
        start_log();
        in_valid = 1'b0;
        wait_log(105);
        for (int c = 0; c <= 105; c++) if (tx_log[c] !== exp_tx(8'h81, 1, c)) bt++;
        checks++;
        if (bt != 0) begin errors++; $display("FAIL rm_clean_frame: bad cycles %0d exp 0", bt); end
        nd = done_count(0, 105);
        checks++;
        if (nd != 1 || done_log[100] !== 1'b1) begin
            errors++;
            $display("FAIL rm_done: got %0d exp 1", nd);
        end
    endtask

    task automatic test_defaults();
        int fall1 = -1, rise1 = -1, fall2 = -1;
        logic prev;
        do_reset();
        def_byte = 8'h01;
        def_valid = 1'b1;
        step();
        def_valid = 1'b0;
        prev = 1'b1;
        for (int c = 0; c <= 20840 && fall2 < 0; c++) begin
            @(negedge clk);
            if (prev === 1'b1 && def_tx === 1'b0) begin
                if (fall1 < 0) fall1 = c;
                else fall2 = c;
            end
            if (prev === 1'b0 && def_tx === 1'b1 && rise1 < 0) rise1 = c;
            prev = def_tx;
        end
        checks++;
        if (fall1 != 1) begin errors++; $display("FAIL def_start: got %0d exp 1", fall1); end
        checks++;
        if (rise1 - fall1 != 10416) begin
            errors++;
            $display("FAIL def_start_len: got %0d exp 10416", rise1 - fall1);
        end
        checks++;
        if (fall2 - rise1 != 10416) begin
            errors++;
            $display("FAIL def_bit_len: got %0d exp 10416", fall2 - rise1);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_byte = 8'h00;
        def_valid = 1'b0;
        def_byte = 8'h00;
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_push_pop();
        test_reset_mid();
        test_defaults();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
